// File: rtl/aes_enc_pkg.sv
// -----------------------------------------------------------------------------
// aes_enc_pkg
// Shared definitions for the AES-128 encryption controller and its datapath:
//   - aes_enc_state_e : controller state encoding
//   - STEP_*          : datapath step-mux encodings (shared with the datapath)
//   - AES_NR          : default number of rounds
//   - is_busy_state() : true for every state except IDLE and DONE
// -----------------------------------------------------------------------------
package aes_enc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARK,
        ST_SUB,
        ST_SHIFT,
        ST_MIX0,
        ST_MIX1,
        ST_MIX2,
        ST_MIX3,
        ST_DONE
    } aes_enc_state_e;

    localparam logic [1:0] STEP_ARK   = 2'b00;
    localparam logic [1:0] STEP_SHIFT = 2'b01;
    localparam logic [1:0] STEP_SUB   = 2'b10;
    localparam logic [1:0] STEP_MIX   = 2'b11;

    localparam int unsigned AES_NR = 10;

    function automatic logic is_busy_state(input aes_enc_state_e s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/aes_enc_round_ctr.sv
// -----------------------------------------------------------------------------
// aes_enc_round_ctr
// 4-bit round index register for the encryption controller.
// Ports:
//   CLK, RESET  : clock, synchronous active-high reset
//   clr_i       : clear round to 0 (takes priority over increment)
//   inc_i       : advance round by one (saturates at NR)
//   round_o     : current round index
//   last_o      : high when round_o equals NR
// Parameter NR : number of rounds, 1..15
// -----------------------------------------------------------------------------
module aes_enc_round_ctr
    import aes_enc_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] round_o,
    output logic       last_o
);

    localparam logic [3:0] NR_W = 4'(NR);

    logic [3:0] round_q;
    logic [3:0] round_d;

    assign last_o  = (round_q == NR_W);
    assign round_o = round_q;

    always_comb begin
        round_d = round_q;
        if (clr_i) begin
            round_d = '0;
        end else if (inc_i && !last_o) begin
            round_d = round_q + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            round_q <= '0;
        end else begin
            round_q <= round_d;
        end
    end

endmodule

// File: rtl/aes_enc_control.sv
// -----------------------------------------------------------------------------
// aes_enc_control
// Control FSM for the AES-128 encryption datapath. A level AES_START in IDLE
// loads the plaintext, then sequences AddRoundKey, SubBytes, ShiftRows and a
// word-serial MixColumns through NR rounds, then holds AES_DONE until
// AES_START is withdrawn.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset
//   AES_START  : level start request
//   AES_DONE   : high in DONE only
//   BUSY       : high in every state except IDLE and DONE
//   round      : round index (round-key select)
//   step       : datapath op (00 ARK, 01 SHIFT, 10 SUB, 11 MIX)
//   word_sl    : MixColumns column select, 0 outside MIX states
//   msg_ld     : load plaintext (LOAD only)
//   state_ld   : write datapath result (every operation state)
// Parameter NR : number of rounds, 1..15
// Build option AES_ENC_ABORT_EN: dropping AES_START in any busy state returns
//   the block to IDLE at the next edge with round cleared and no DONE.
// -----------------------------------------------------------------------------
module aes_enc_control
    import aes_enc_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       AES_START,
    output logic       AES_DONE,
    output logic       BUSY,
    output logic [3:0] round,
    output logic [1:0] step,
    output logic [1:0] word_sl,
    output logic       msg_ld,
    output logic       state_ld
);

    aes_enc_state_e state_q;
    aes_enc_state_e state_d;

    logic       done_q;
    logic       busy_q;
    logic [1:0] step_q;
    logic [1:0] word_q;
    logic       msg_ld_q;
    logic       state_ld_q;

    logic       last_round;
    logic       rnd_clr;
    logic       rnd_inc;

    aes_enc_round_ctr #(
        .NR (NR)
    ) u_round_ctr (
        .CLK     (CLK),
        .RESET   (RESET),
        .clr_i   (rnd_clr),
        .inc_i   (rnd_inc),
        .round_o (round),
        .last_o  (last_round)
    );

    // Clearing on entry to IDLE (not while in it) makes round read 0 in the
    // very first IDLE cycle, including after DONE or an abort.
    assign rnd_clr = (state_d == ST_IDLE);
    assign rnd_inc = (state_q == ST_ARK) && (state_d == ST_SUB);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (AES_START) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_ARK;
            ST_ARK:   state_d = last_round ? ST_DONE : ST_SUB;
            ST_SUB:   state_d = ST_SHIFT;
            ST_SHIFT: state_d = last_round ? ST_ARK : ST_MIX0;
            ST_MIX0:  state_d = ST_MIX1;
            ST_MIX1:  state_d = ST_MIX2;
            ST_MIX2:  state_d = ST_MIX3;
            ST_MIX3:  state_d = ST_ARK;
            ST_DONE:  if (!AES_START) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
`ifdef AES_ENC_ABORT_EN
        if (is_busy_state(state_q) && !AES_START) begin
            state_d = ST_IDLE;
        end
`endif
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they line up with state_q exactly as a decode of state_q would.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            step_q     <= STEP_ARK;
            word_q     <= '0;
            msg_ld_q   <= 1'b0;
            state_ld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= (state_d == ST_DONE);
            busy_q     <= is_busy_state(state_d);
            msg_ld_q   <= (state_d == ST_LOAD);
            state_ld_q <= is_busy_state(state_d) && (state_d != ST_LOAD);
            case (state_d)
                ST_SUB:   begin step_q <= STEP_SUB;   word_q <= 2'd0; end
                ST_SHIFT: begin step_q <= STEP_SHIFT; word_q <= 2'd0; end
                ST_MIX0:  begin step_q <= STEP_MIX;   word_q <= 2'd0; end
                ST_MIX1:  begin step_q <= STEP_MIX;   word_q <= 2'd1; end
                ST_MIX2:  begin step_q <= STEP_MIX;   word_q <= 2'd2; end
                ST_MIX3:  begin step_q <= STEP_MIX;   word_q <= 2'd3; end
                default:  begin step_q <= STEP_ARK;   word_q <= 2'd0; end
            endcase
        end
    end

    assign AES_DONE = done_q;
    assign BUSY     = busy_q;
    assign step     = step_q;
    assign word_sl  = word_q;
    assign msg_ld   = msg_ld_q;
    assign state_ld = state_ld_q;

endmodule

// File: doc/aes_enc_control.md
# aes_enc_control

Control state machine for the AES-128 encryption datapath, the forward-direction counterpart of the decryption controller. On a level START it loads the plaintext, then sequences AddRoundKey, SubBytes, ShiftRows and a word-serial MixColumns through NR rounds. It drives the shared datapath's step select, column-word select, round-key index and register enables, and holds DONE until START is withdrawn.

## Interface
- NR, 10, number of rounds; legal range 1..15 (round index is 4 bits)
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  reset, synchronous, active-high
- AES_START  in  1  level request; a new operation starts when sampled high in IDLE
- AES_DONE  out  1  high in DONE state only
- BUSY  out  1  high in every state except IDLE and DONE
- round  out  4  current round index; selects the round key for AddRoundKey
- step  out  2  datapath operation: 00 AddRoundKey, 01 ShiftRows, 10 SubBytes, 11 MixColumns
- word_sl  out  2  MixColumns column select 0..3; 0 outside MIX states
- msg_ld  out  1  load plaintext into the state register (LOAD state only)
- state_ld  out  1  write the datapath result into the state register (every operation state)

## Operation
- States: IDLE, LOAD, ARK, SUB, SHIFT, MIX0, MIX1, MIX2, MIX3, DONE.
- IDLE: round cleared to 0; if AES_START = 1, go to LOAD.
- LOAD: msg_ld = 1; go to ARK.
- ARK: step = 00, state_ld = 1.
  - If round = NR, go to DONE with round held.
  - Otherwise increment round and go to SUB.
- SUB: step = 10, state_ld = 1; go to SHIFT.
- SHIFT: step = 01, state_ld = 1.
  - If round = NR, go to ARK (final round, no MixColumns).
  - Otherwise go to MIX0.
- MIXn: step = 11, word_sl = n, state_ld = 1; MIX0 → MIX1 → MIX2 → MIX3 → ARK.
- DONE: AES_DONE = 1, round = NR.
  - Stay while AES_START = 1.
  - Go to IDLE when AES_START = 0.
- All outputs are fully driven (never Z). Inactive values: step = 00, word_sl = 0, msg_ld = 0, state_ld = 0.
- round changes only on ARK exit (increment) and in IDLE (clear). It never exceeds NR.
- Without the abort feature, AES_START is ignored from LOAD through the final ARK.

## Timing
- Reset values: state IDLE, round 0, AES_DONE 0, BUSY 0, step 00, word_sl 0, msg_ld 0, state_ld 0.
- RESET has priority over everything. Asserting it in any state returns the block to IDLE at the next edge, and no DONE is produced.
- If AES_START is still high when RESET releases, a new operation starts; no re-arm is required.
- Outputs are combinational from state and round. step and word_sl are valid in the same cycle as the state.
- Latency: AES_START sampled in IDLE at edge k gives LOAD after edge k. For NR = 10:
  - ARK round 0 after edge k+1.
  - ARK round r after edge k+1+7r.
  - Final SUB / SHIFT / ARK after edges k+65 / k+66 / k+67.
  - AES_DONE high after edge k+68.
  - General case: 7·NR − 2 busy cycles.
- After AES_START falls in DONE, AES_DONE falls after the next edge. A new start needs at least one IDLE cycle.
- NR = 1: LOAD, ARK0, SUB, SHIFT, ARK1, DONE (no MIX states).

## Configuration
- AES_ENC_ABORT_EN defined: AES_START = 0 in any BUSY state sends the block to IDLE at the next edge. round is cleared to 0 and no DONE pulse is produced.
- AES_ENC_ABORT_EN undefined: an operation always runs to DONE once started, regardless of AES_START.

## Structure
- Package aes_enc_pkg holds:
  - the state enum type;
  - step encodings STEP_ARK = 2'b00, STEP_SHIFT = 2'b01, STEP_SUB = 2'b10, STEP_MIX = 2'b11, shared with the datapath step mux;
  - the default round count constant AES_NR = 10.
- One sub-module, aes_enc_round_ctr, contains the 4-bit round register. Inputs are clear, increment and NR; outputs are round and a last-round flag.
- The FSM stays in the top module.

## Test plan
- Reset, then pulse AES_START high and hold it:
  - LOAD with msg_ld = 1 on the first busy cycle;
  - AES_DONE rises exactly 68 cycles after AES_START is sampled;
  - round = 10 in DONE.
- Step trace over a full run: sequence ARK(0), then SUB/SHIFT/MIX0-3/ARK for rounds 1-9, then SUB/SHIFT/ARK(10). word_sl counts 0,1,2,3 in MIX states only. state_ld has 67 high cycles.
- Hold AES_START in DONE for 20 cycles: AES_DONE stays 1 throughout. Drop AES_START: IDLE next cycle, round = 0.
- Assert RESET during MIX2 of round 5 with AES_START high: IDLE next edge. After release, a fresh operation starts with LOAD and completes 68 cycles later.
- Drop AES_START during round 3, for both settings of the macro:
  - with AES_ENC_ABORT_EN: IDLE next edge, no AES_DONE;
  - without it: the run completes, AES_DONE is asserted one cycle, then IDLE.
- Set NR = 1: state sequence LOAD, ARK, SUB, SHIFT, ARK, DONE, with AES_DONE after 5 busy cycles.
